fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter sharing one 8-bit FIFO between N producers. Each producer raises a request with its data word. The arbiter grants one producer at a time and drives the FIFO `wr_en`/`din` from that producer, never writing while the FIFO reports `full`. It sits directly in front of the `fifo` block's write port; the read port is untouched.

---
 rtl/fifo_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write-port arbiter that shares one FIFO write port between N
// producers. One producer holds the grant at a time. Its word is forwarded to
// the FIFO in every cycle where it still requests and the FIFO is not full.
// After a release the search for the next grant starts one position past the
// producer that was just served.
//
// Optional feature (compile-time macro): FIFO_ARB_BURST_EN
//   defined   : a grant covers up to MAX_BURST consecutive writes.
//   undefined : a grant is released after every single write, and the
//               burst counter is not built.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   req        in   N      per-producer request, held with data until acked
//   din_bus    in   N*DW   producer i data on bits [i*DW +: DW]
//   full       in   1      FIFO full flag
//   gnt        out  N      registered one-hot grant, zero when idle
//   ack        out  N      one-hot, high while producer i's word is written
//   fifo_wr_en out  1      FIFO write enable
//   fifo_din   out  DW     data of the granted producer, zero when idle
//   busy       out  1      high while a grant is held
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] din_bus,
    input  logic            full,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    ack,
    output logic            fifo_wr_en,
    output logic [DW-1:0]   fifo_din,
    output logic            busy
);

    localparam int LW = $clog2(N);

    if (N < 2 || N > 8 || DW < 1 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_params
        $error("fifo_wr_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [LW-1:0] last;      // index of the most recently released grant
    logic [LW-1:0] gidx;      // index of the current grant
    logic [LW-1:0] next_idx;
    logic          any_req;
    logic          req_g;
    logic          xfer;
    logic          last_write;

`ifdef FIFO_ARB_BURST_EN
    logic [3:0]    bcnt;
    // Release on the write that brings the count up to MAX_BURST.
    assign last_write = (({1'b0, bcnt} + 5'd1) == 5'(MAX_BURST));
`else
    assign last_write = 1'b1;
`endif

    // Round-robin search: first requester at or after last+1, wrapping mod N.
    always_comb begin
        int unsigned cand;
        logic        found;
        cand     = 0;
        found    = 1'b0;
        next_idx = last;
        any_req  = |req;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last) + k) % N;
            if (!found && req[LW'(cand)]) begin
                found    = 1'b1;
                next_idx = LW'(cand);
            end
        end
    end

    // Transfer path is combinational so a write can land in the first
    // granted cycle. The reset term keeps the FIFO untouched in the reset
    // cycle even while a grant is still registered.
    assign req_g      = |(req & gnt);
    assign xfer       = (state == GRANT) && req_g && !full && !rst;
    assign fifo_wr_en = xfer;
    assign ack        = gnt & {N{xfer}};
    assign busy       = (state == GRANT);

    // gnt is all-zero when idle, so the mux naturally outputs zero then.
    always_comb begin
        fifo_din = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                fifo_din = din_bus[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            gidx  <= '0;
            last  <= LW'(N - 1);
`ifdef FIFO_ARB_BURST_EN
            bcnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= GRANT;
                        gidx  <= next_idx;
                        gnt   <= {{(N-1){1'b0}}, 1'b1} << next_idx;
`ifdef FIFO_ARB_BURST_EN
                        bcnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    // full with req[g] high falls through: hold, no count.
                    if (!req_g || (xfer && last_write)) begin
                        state <= IDLE;
                        gnt   <= '0;
                        last  <= gidx;
                    end
`ifdef FIFO_ARB_BURST_EN
                    if (xfer && (bcnt < 4'(MAX_BURST))) begin
                        bcnt <= bcnt + 4'd1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Scoreboard bench for fifo_wr_arbiter (N=4, DW=8, MAX_BURST=4). Scenarios
// push the expected FIFO writes as {cycle, producer, data}. A monitor pops one
// entry for every write it observes on the FIFO port and compares the cycle,
// the ack vector and the data. Producers keep their request up until they
// have been acked the requested number of times. Expectations follow
// FIFO_ARB_BURST_EN when it is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] din_bus;
    logic            full;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic            busy;

    fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din_bus    (din_bus),
        .full       (full),
        .gnt        (gnt),
        .ack        (ack),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] ack_seen = '0;
    int           rem[N];

    // Monitor: every FIFO write must match the next scoreboard entry.
    initial begin
        exp_t         e;
        logic [N-1:0] exp_ack;
        forever begin
            @(negedge clk);
            ack_seen = ack;
            if (fifo_wr_en === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cyc=%0d ack=%b din=%h required no write",
                             cyc, ack, fifo_din);
                end else begin
                    e = q.pop_front();
                    exp_ack = '0;
                    exp_ack[e.idx] = 1'b1;
                    if (cyc != e.cyc || ack !== exp_ack || fifo_din !== e.data) begin
                        errors++;
                        $display("FAIL write got cyc=%0d ack=%b din=%h required cyc=%0d ack=%b din=%h",
                                 cyc, ack, fifo_din, e.cyc, exp_ack, e.data);
                    end
                end
            end else if (fifo_wr_en === 1'b0) begin
                checks++;
                if (ack !== '0) begin
                    errors++;
                    $display("FAIL ack_without_write cyc=%0d ack=%b required 0000", cyc, ack);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h required %h", name, cyc, act, exp);
        end
    endtask

    // One cycle; producers drop req after their last acked word.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i] && rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) req[i] = 1'b0;
            end
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start(input int i, input int n);
        req[i] = 1'b1;
        rem[i] = n;
    endtask

    task automatic expect_wr(input int c, input int i, input logic [DW-1:0] d);
        exp_t e;
        e.cyc  = c;
        e.idx  = i;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", q.size());
            q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        full = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst     = 1'b1;
        req     = '0;
        full    = 1'b0;
        din_bus = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_gnt",   32'(gnt), 32'h0);
        chk("rst_ack",   32'(ack), 32'h0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_din",   32'(fifo_din), 32'h0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_gnt",  32'(gnt), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Single requester 2, three words of 8'h3C
        do_reset();
        t0 = cyc;
        din_bus[2*DW +: DW] = 8'h3C;
        start(2, 3);
`ifdef FIFO_ARB_BURST_EN
        for (int k = 1; k <= 3; k++) expect_wr(t0 + k, 2, 8'h3C);
`else
        for (int k = 0; k < 3; k++) expect_wr(t0 + 1 + 2*k, 2, 8'h3C);
`endif
        goto(t0 + 1);
        @(negedge clk);
        chk("s1_gnt",  32'(gnt), 32'h4);
        chk("s1_busy", 32'(busy), 32'h1);
`ifndef FIFO_ARB_BURST_EN
        goto(t0 + 2);
        @(negedge clk);
        chk("s1_bubble_gnt", 32'(gnt), 32'h0);
        chk("s1_bubble_din", 32'(fifo_din), 32'h0);
`endif
        drain();

        // Round robin, all four requesting, two words each
        do_reset();
        t0 = cyc;
        din_bus = 32'h13121110;
        for (int i = 0; i < N; i++) start(i, 2);
`ifdef FIFO_ARB_BURST_EN
        for (int j = 0; j < 4; j++) begin
            expect_wr(t0 + 1 + 4*j, j, 8'(8'h10 + j));
            expect_wr(t0 + 2 + 4*j, j, 8'(8'h10 + j));
        end
`else
        for (int k = 0; k < 8; k++) expect_wr(t0 + 1 + 2*k, k % 4, 8'(8'h10 + (k % 4)));
`endif
        goto(t0 + 1);
        @(negedge clk);
        chk("s2_first_gnt", 32'(gnt), 32'h1);
        drain();

        // Two requesters with four words each: burst limit / alternation
        do_reset();
        t0 = cyc;
        din_bus = 32'h0000B1A0;
        start(0, 4);
        start(1, 4);
`ifdef FIFO_ARB_BURST_EN
        for (int k = 0; k < 4; k++) expect_wr(t0 + 1 + k, 0, 8'hA0);
        for (int k = 0; k < 4; k++) expect_wr(t0 + 6 + k, 1, 8'hB1);
`else
        for (int k = 0; k < 8; k++) expect_wr(t0 + 1 + 2*k, k % 2, (k % 2 == 1) ? 8'hB1 : 8'hA0);
`endif
        drain();

        // Full stall on producer 1 for five cycles; producer 0 waits
        do_reset();
        t0 = cyc;
        din_bus = 32'h0000B1A0;
        start(1, 4);
`ifdef FIFO_ARB_BURST_EN
        expect_wr(t0 + 1, 1, 8'hB1);
        expect_wr(t0 + 2, 1, 8'hB1);
        expect_wr(t0 + 8, 1, 8'hB1);
        expect_wr(t0 + 9, 1, 8'hB1);
        expect_wr(t0 + 11, 0, 8'hA0);
`else
        expect_wr(t0 + 1, 1, 8'hB1);
        expect_wr(t0 + 8, 1, 8'hB1);
        expect_wr(t0 + 10, 0, 8'hA0);
        expect_wr(t0 + 12, 1, 8'hB1);
        expect_wr(t0 + 14, 1, 8'hB1);
`endif
        goto(t0 + 3);
        full = 1'b1;
        start(0, 1);
        for (int c = 3; c <= 7; c++) begin
            goto(t0 + c);
            @(negedge clk);
            chk("stall_gnt",   32'(gnt), 32'h2);
            chk("stall_wr_en", 32'(fifo_wr_en), 32'h0);
            chk("stall_ack",   32'(ack), 32'h0);
        end
        goto(t0 + 8);
        full = 1'b0;
        drain();

        // Producer 3 stops early; next grant wraps to 0 then 1
        do_reset();
        t0 = cyc;
        din_bus = 32'hD300B1A0;
        start(3, 2);
`ifdef FIFO_ARB_BURST_EN
        expect_wr(t0 + 1, 3, 8'hD3);
        expect_wr(t0 + 2, 3, 8'hD3);
        expect_wr(t0 + 5, 0, 8'hA0);
        expect_wr(t0 + 8, 1, 8'hB1);
`else
        expect_wr(t0 + 1, 3, 8'hD3);
        expect_wr(t0 + 3, 0, 8'hA0);
        expect_wr(t0 + 5, 1, 8'hB1);
        expect_wr(t0 + 7, 3, 8'hD3);
`endif
        goto(t0 + 2);
        start(0, 1);
        start(1, 1);
`ifdef FIFO_ARB_BURST_EN
        goto(t0 + 3);
        @(negedge clk);
        chk("drop_hold_gnt", 32'(gnt), 32'h8);
        chk("drop_hold_ack", 32'(ack), 32'h0);
        goto(t0 + 5);
`else
        goto(t0 + 3);
`endif
        @(negedge clk);
        chk("wrap_gnt", 32'(gnt), 32'h1);
        drain();

        // Reset pulsed while producer 2 holds the grant
        do_reset();
        t0 = cyc;
        din_bus = 32'h005A0077;
        start(2, 10);
        expect_wr(t0 + 1, 2, 8'h5A);
`ifdef FIFO_ARB_BURST_EN
        expect_wr(t0 + 2, 2, 8'h5A);
        expect_wr(t0 + 5, 0, 8'h77);
        expect_wr(t0 + 8, 2, 8'h5A);
`else
        expect_wr(t0 + 5, 0, 8'h77);
        expect_wr(t0 + 7, 2, 8'h5A);
`endif
        goto(t0 + 3);
        rst = 1'b1;
        start(0, 1);
        @(negedge clk);
        chk("mrst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("mrst_ack",   32'(ack), 32'h0);
        chk("mrst_gnt",   32'(gnt), 32'h4);
        goto(t0 + 4);
        rst = 1'b0;
        rem[2] = 1;
        @(negedge clk);
        chk("mrst_after_gnt",  32'(gnt), 32'h0);
        chk("mrst_after_busy", 32'(busy), 32'h0);
        chk("mrst_after_din",  32'(fifo_din), 32'h0);
        goto(t0 + 5);
        @(negedge clk);
        chk("mrst_first_gnt", 32'(gnt), 32'h1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
